inferno_rom_loader: RTL and testbench
=====================================

INFERNO_ROM_LOADER -- requirements
Module: inferno_rom_loader

Interface
REQ-001 Parameter ROM_SIZE, default 18'h30000; number of bytes expected in download index 0.
REQ-002 Parameter HOLD_CYCLES, default 16; reset-stretch length after a download ends.
REQ-003 Parameter EXP_SUM, default 8'h00; expected additive checksum, used only when the Configuration macro is defined.
REQ-004 clock_12  in  1  system clock; single clock domain.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 ioctl_download  in  1  download window active.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte address.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 ioctl_index  in  16  download slot.
REQ-011 dn_addr  out  18  registered address to williams2.
REQ-012 dn_data  out  8  registered data.
REQ-013 dn_wr  out  1  registered write strobe.
REQ-014 core_reset  out  1  holds williams2 in reset.
REQ-015 rom_ok  out  1  ROM image complete and accepted.
REQ-016 rom_err  out  1  short, overflowed or (if enabled) checksum-mismatched image.

Function
REQ-017 States: IDLE, LOAD, HOLD, RUN, ERR; encoded in the shared package.
REQ-018 IDLE -> LOAD when ioctl_download=1 and ioctl_index=0; byte counter and checksum cleared on entry.
REQ-019 LOAD: each ioctl_wr with ioctl_addr < ROM_SIZE drives dn_addr=ioctl_addr[17:0], dn_data=ioctl_dout, dn_wr=1 exactly one cycle later; one dn_wr per ioctl_wr.
REQ-020 LOAD: ioctl_wr with ioctl_addr >= ROM_SIZE produces no dn_wr and sets a sticky overflow flag.
REQ-021 Byte counter: 18 bits, incremented per accepted write, saturates at 18'h3FFFF, no wrap.
REQ-022 LOAD exit on ioctl_download falling: counter = ROM_SIZE and no overflow -> HOLD; otherwise -> ERR.
REQ-023 HOLD: counts HOLD_CYCLES clocks, then -> RUN; rom_ok=1 in RUN only.
REQ-024 core_reset=1 in IDLE, LOAD, HOLD and ERR; core_reset=0 only in RUN.
REQ-025 Any state: ioctl_download rising with index 0 -> LOAD and clears rom_ok/rom_err; downloads with index != 0 are ignored, no dn_wr.
REQ-026 ioctl_wr coincident with ioctl_download falling is accepted before the exit decision.
REQ-027 rom_err=1 only in ERR; ERR exits only via a new index-0 download or reset.

Reset
REQ-028 Reset, asynchronous: state=IDLE, dn_addr=0, dn_data=0, dn_wr=0, core_reset=1, rom_ok=0, rom_err=0, counters=0, overflow=0.
REQ-029 Reset asserted mid-LOAD abandons the load; after release, LOAD is re-entered only on a new ioctl_download rising edge.

Configuration
REQ-030 Macro INFERNO_ROM_CHECKSUM_EN defined: 8-bit modulo-256 sum of accepted bytes, compared with EXP_SUM at LOAD exit; mismatch -> ERR.
REQ-031 Macro undefined: no checksum logic; EXP_SUM ignored; acceptance is by length and overflow only.

Structure
REQ-032 Package inferno_pkg holds the loader state enum, the ROM_SIZE default constant and the index-0 constant.
REQ-033 Sub-module inferno_hold_timer (load/count/done) implements the HOLD counter; no other sub-modules.

Verification
REQ-034 Full load: 0x30000 bytes at index 0, addresses 0..0x2FFFF -> 0x30000 dn_wr pulses, each one cycle after ioctl_wr; RUN after 16 HOLD clocks; rom_ok=1, core_reset=0.
REQ-035 Short load: 0x100 bytes then download ends -> ERR, rom_err=1, core_reset=1.
REQ-036 Overflow: write at addr 0x30000 -> no dn_wr; ERR at end.
REQ-037 Index 2 download during RUN -> no dn_wr, rom_ok stays 1.
REQ-038 Reset pulse at byte 0x1000 -> all outputs at reset values; a new full load then reaches RUN.
REQ-039 INFERNO_ROM_CHECKSUM_EN, EXP_SUM=8'h5A, image summing to 8'h5B -> ERR; image summing to 8'h5A -> RUN.

Source files
------------

// File: rtl/inferno_pkg.sv
// Shared types and constants for the Inferno ROM download path.
package inferno_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHold,
    StRun,
    StErr
  } loader_state_e;

  localparam logic [17:0] ROM_SIZE_DEFAULT = 18'h30000;
  localparam logic [15:0] ROM_INDEX        = 16'd0;
  localparam logic [17:0] BYTE_CNT_MAX     = 18'h3FFFF;

endpackage

// File: rtl/inferno_hold_timer.sv
// Reset-stretch timer: cleared by load, advances while count is high.
// done is high on the last of HOLD_CYCLES counting clocks.
module inferno_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic clock_12,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int unsigned W = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt;

  assign done = count && (cnt == LAST);

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/inferno_rom_loader.sv
// Forwards the index-0 ROM download to williams2 and holds the core in reset until the image
// is complete. Define INFERNO_ROM_CHECKSUM_EN to also require an 8-bit additive sum of EXP_SUM.
module inferno_rom_loader
  import inferno_pkg::*;
#(
  parameter logic [17:0] ROM_SIZE    = ROM_SIZE_DEFAULT,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [7:0]  EXP_SUM     = 8'h00
) (
  input  logic        clock_12,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] ioctl_index,
  output logic [17:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        rom_err
);

  loader_state_e state, state_next;
  logic          dl_prev;
  logic [17:0]   byte_cnt, byte_cnt_next;
  logic          overflow, overflow_next;
  logic          start, in_range, accept, image_ok, hold_done;

`ifdef INFERNO_ROM_CHECKSUM_EN
  logic [7:0] sum, sum_next;
`else
  logic unused_exp_sum;
  assign unused_exp_sum = ^EXP_SUM;
`endif

  always_comb begin
    start         = ioctl_download && !dl_prev && (ioctl_index == ROM_INDEX);
    in_range      = ioctl_addr < {7'd0, ROM_SIZE};
    accept        = (state == StLoad) && ioctl_wr && in_range;
    byte_cnt_next = byte_cnt;
    if (accept && byte_cnt != BYTE_CNT_MAX) byte_cnt_next = byte_cnt + 1'b1;
    overflow_next = overflow || ((state == StLoad) && ioctl_wr && !in_range);
`ifdef INFERNO_ROM_CHECKSUM_EN
    sum_next      = accept ? sum + ioctl_dout : sum;
    image_ok      = (byte_cnt_next == ROM_SIZE) && !overflow_next && (sum_next == EXP_SUM);
`else
    image_ok      = (byte_cnt_next == ROM_SIZE) && !overflow_next;
`endif
    // A write coincident with download falling is folded into the exit decision.
    state_next = state;
    if (start) begin
      state_next = StLoad;
    end else begin
      case (state)
        StLoad:  if (!ioctl_download) state_next = image_ok ? StHold : StErr;
        StHold:  if (hold_done) state_next = StRun;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      // Start high so a download still asserted across reset is not seen as a new rising edge.
      dl_prev    <= 1'b1;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_wr      <= 1'b0;
      core_reset <= 1'b1;
      rom_ok     <= 1'b0;
      rom_err    <= 1'b0;
      byte_cnt   <= '0;
      overflow   <= 1'b0;
`ifdef INFERNO_ROM_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= state_next;
      dl_prev    <= ioctl_download;
      dn_wr      <= accept;
      if (accept) begin
        dn_addr <= ioctl_addr[17:0];
        dn_data <= ioctl_dout;
      end
      core_reset <= state_next != StRun;
      rom_ok     <= state_next == StRun;
      rom_err    <= state_next == StErr;
      if (start) begin
        byte_cnt <= '0;
        overflow <= 1'b0;
`ifdef INFERNO_ROM_CHECKSUM_EN
        sum      <= '0;
`endif
      end else begin
        byte_cnt <= byte_cnt_next;
        overflow <= overflow_next;
`ifdef INFERNO_ROM_CHECKSUM_EN
        sum      <= sum_next;
`endif
      end
    end
  end

  inferno_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clock_12(clock_12),
    .reset   (reset),
    .load    (state != StHold),
    .count   (state == StHold),
    .done    (hold_done)
  );

endmodule

// File: tb/tb_inferno_rom_loader.sv
// Scoreboard bench for inferno_rom_loader with a reduced ROM size and randomized images.
module tb_inferno_rom_loader;

  localparam logic [17:0] ROM    = 18'h1000;
  localparam int          HOLD   = 16;
  localparam logic [7:0]  SUM_OK = 8'h5A;

  logic        clock_12 = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [15:0] ioctl_index = '0;
  logic [17:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        rom_ok;
  logic        rom_err;

  inferno_rom_loader #(
    .ROM_SIZE   (ROM),
    .HOLD_CYCLES(HOLD),
    .EXP_SUM    (SUM_OK)
  ) dut (
    .clock_12      (clock_12),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .core_reset    (core_reset),
    .rom_ok        (rom_ok),
    .rom_err       (rom_err)
  );

  always #5 clock_12 = ~clock_12;

  int cyc = 0;
  always @(posedge clock_12) cyc++;

  int total = 0;
  int bad = 0;

  // Reference model: an index-0 download is a list of bytes; good iff exactly ROM bytes landed
  // in range, nothing fell outside it, and (optionally) the bytes sum to SUM_OK.
  bit         m_loading = 1'b0;
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] m_sum = '0;

  typedef struct {
    int          cyc;
    logic [17:0] a;
    logic [7:0]  d;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock_12) begin
    if (!reset && dn_wr) begin
      if (sb.size() == 0) begin
        chk("unexpected_dn_wr", 32'(dn_wr), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dn_wr_latency", cyc, e.cyc + 1);
        chk("dn_addr", 32'(dn_addr), 32'(e.a));
        chk("dn_data", 32'(dn_data), 32'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clock_12);
    #1;
  endtask

  task automatic model_wr(input logic [24:0] a, input logic [7:0] d);
    if (m_loading) begin
      if (a < {7'd0, ROM}) begin
        sb.push_back('{cyc, a[17:0], d});
        if (m_cnt < 'h3FFFF) m_cnt++;
        m_sum = m_sum + d;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    model_wr(a, d);
    tick();
    ioctl_wr = 1'b0;
    if ($urandom_range(0, 3) == 0) tick();
  endtask

  task automatic start(input logic [15:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == 16'd0) begin
      m_loading = 1'b1;
      m_cnt     = 0;
      m_ovf     = 1'b0;
      m_sum     = '0;
    end
    tick();
  endtask

  // Sends all but the last byte of an n-byte image over permuted addresses; returns the last.
  task automatic send_image(input int n, input bit fix, input logic [7:0] target,
                            output logic [24:0] la, output logic [7:0] ld);
    int mask;
    mask = $urandom_range(0, int'(ROM) - 1);
    for (int i = 0; i < n - 1; i++) wr(25'(i ^ mask), 8'($urandom));
    la = 25'((n - 1) ^ mask);
    ld = fix ? 8'(target - m_sum) : 8'($urandom);
  endtask

  task automatic end_load(input logic [24:0] la, input logic [7:0] ld, input string tag);
    bit ok;
    int k;
    ioctl_download = 1'b0;
    ioctl_addr     = la;
    ioctl_dout     = ld;
    ioctl_wr       = 1'b1;
    model_wr(la, ld);
    ok = m_loading && (m_cnt == int'(ROM)) && !m_ovf;
`ifdef INFERNO_ROM_CHECKSUM_EN
    ok = ok && (m_sum == SUM_OK);
`endif
    m_loading = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    chk({tag, "/core_reset_after_exit"}, 32'(core_reset), 32'd1);
    chk({tag, "/rom_err_after_exit"}, 32'(rom_err), 32'(!ok));
    chk({tag, "/rom_ok_after_exit"}, 32'(rom_ok), 32'd0);
    if (ok) begin
      k = 0;
      while (core_reset && k < 64) begin
        tick();
        k++;
      end
      chk({tag, "/hold_length"}, k, HOLD);
      chk({tag, "/rom_ok_run"}, 32'(rom_ok), 32'd1);
      chk({tag, "/rom_err_run"}, 32'(rom_err), 32'd0);
    end
    tick();
    tick();
    chk({tag, "/scoreboard_drained"}, sb.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/dn_addr"}, 32'(dn_addr), 32'd0);
    chk({tag, "/dn_data"}, 32'(dn_data), 32'd0);
    chk({tag, "/dn_wr"}, 32'(dn_wr), 32'd0);
    chk({tag, "/core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "/rom_ok"}, 32'(rom_ok), 32'd0);
    chk({tag, "/rom_err"}, 32'(rom_err), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [24:0] la;
    logic [7:0]  ld;

    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();
    tick();

    start(16'd0);
    send_image(int'(ROM), 1'b1, SUM_OK, la, ld);
    end_load(la, ld, "full");

    start(16'd2);
    for (int i = 0; i < 20; i++) wr(25'($urandom_range(0, int'(ROM) - 1)), 8'($urandom));
    ioctl_download = 1'b0;
    tick();
    tick();
    chk("idx2/rom_ok", 32'(rom_ok), 32'd1);
    chk("idx2/core_reset", 32'(core_reset), 32'd0);
    chk("idx2/rom_err", 32'(rom_err), 32'd0);

    start(16'd0);
    send_image(256, 1'b0, 8'h00, la, ld);
    end_load(la, ld, "short");
    repeat (5) tick();
    chk("short/rom_err_sticky", 32'(rom_err), 32'd1);
    chk("short/core_reset_sticky", 32'(core_reset), 32'd1);

    start(16'd0);
    send_image(int'(ROM), 1'b1, SUM_OK, la, ld);
    wr({7'd0, ROM}, 8'($urandom));
    wr(25'h1000005, 8'($urandom));
    end_load(la, ld, "ovf");

    start(16'd0);
    send_image(256, 1'b0, 8'h00, la, ld);
    tick();
    tick();
    chk("midreset/scoreboard_drained", sb.size(), 0);
    #2;
    reset     = 1'b1;
    m_loading = 1'b0;
    #1;
    chk_reset_vals("midreset");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) wr(25'($urandom_range(0, int'(ROM) - 1)), 8'($urandom));
    ioctl_download = 1'b0;
    tick();
    tick();
    chk("postreset/core_reset", 32'(core_reset), 32'd1);
    chk("postreset/rom_err", 32'(rom_err), 32'd0);
    chk("postreset/rom_ok", 32'(rom_ok), 32'd0);

    start(16'd0);
    send_image(int'(ROM), 1'b1, SUM_OK, la, ld);
    end_load(la, ld, "reload");

`ifdef INFERNO_ROM_CHECKSUM_EN
    start(16'd0);
    send_image(int'(ROM), 1'b1, 8'h5B, la, ld);
    end_load(la, ld, "sum_bad");
    start(16'd0);
    send_image(int'(ROM), 1'b1, SUM_OK, la, ld);
    end_load(la, ld, "sum_good");
`endif

    chk("final/scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
